readin_ctrl: RTL and testbench
==============================

# readin_ctrl

Round controller for the LED-drain reaction game. It drives the `en` input of the 16-bit LED shift stage and consumes that stage's `readin_en` window flag. Each round it shows a one-hot target on 4 LEDs, accepts one button press while the window is open, and scores the round as a hit or a miss. It ends the game when the lives run out.

## Interface
Parameters:
- `LIVES`, default 3: lives loaded at game start. Legal range 1..15.
- `SCORE_W`, default 8: score counter width.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  level; sampled only in IDLE and OVER.
- `readin_en`  in  1  input-window flag from the LED shift stage. It is high while `led[1:0]==2'b11`.
- `btn`  in  4  push buttons; already synchronized and debounced upstream; active-high.
- `shift_en`  out  1  drives the LED shift stage `en`. High means shift right one place per cycle. Low means the LEDs reload to 16'hFFFF on the next edge.
- `target_led`  out  4  one-hot target in PLAY; 0 in every other state.
- `score`  out  SCORE_W  hit count, saturating.
- `lives`  out  4  remaining lives.
- `hit`  out  1  one-cycle pulse on a hit.
- `miss`  out  1  one-cycle pulse on a miss.
- `game_over`  out  1  high while in OVER.

## Operation
- **Reset values:** state IDLE, `shift_en`=0, `target_led`=0, `score`=0, `lives`=0, `hit`=`miss`=`game_over`=0, `btn_prev`=0, LFSR=8'h01.
- **LFSR:** 8-bit Fibonacci LFSR, taps 8,6,5,4. It advances every cycle when not in reset. The target index is `lfsr[1:0]`. It is latched into `tgt` on every entry to PLAY.
- **Press detection:** `rise = btn & ~btn_prev`. `btn_prev` updates every cycle in all states. A press is `rise != 0`. A correct press is `rise == (4'b1 << tgt)`. Two or more bits rising in the same cycle, or a single wrong bit, is a wrong press. Rises outside PLAY are discarded.
- **IDLE:** `shift_en`=0. When `start`=1: set `score`=0 and `lives`=LIVES, latch `tgt`, then go to PLAY.
- **PLAY:** `shift_en`=1 and `target_led`=one-hot(`tgt`). Evaluate in this priority order:
  1. `readin_en`=0 (window closed): miss. This applies even if a press occurs in the same cycle.
  2. Correct press: hit.
  3. Wrong press: miss.
  4. Otherwise: stay in PLAY.
- **On a hit:** `score`+1, saturating at 2^SCORE_W−1. Pulse `hit`. Go to RELOAD.
- **On a miss:** `lives`−1 and pulse `miss`. If the new `lives` value is 0, go to OVER; otherwise go to RELOAD.
- **RELOAD:** one cycle with `shift_en`=0, so the LEDs become 16'hFFFF. Then latch a new `tgt` and go to PLAY.
- **OVER:** `shift_en`=0 and `game_over`=1. `score` holds its value and `lives` stays 0. When `start`=1, behave exactly as IDLE+`start` does.
- **`rst` in any state:** return to IDLE on the next edge with all reset values restored. This includes reset during PLAY, RELOAD, or a pending hit/miss pulse.

## Timing
- All outputs are registered, except `shift_en`, `target_led` and `game_over`, which are Moore decodes of the state register. No combinational path runs from inputs to outputs.
- **Game start:** `start` sampled at edge E puts the block in PLAY from E. The first PLAY cycle sees `led`=16'hFFFF and `readin_en`=1.
- **Window length:** with `shift_en` high, the LED stage reaches 16'h0001 after 15 shifts.
  - Presses are accepted in PLAY cycles 0..14.
  - PLAY cycle 15 sees `readin_en`=0 and scores a timeout miss.
- **Result timing:** `hit`/`miss`, `score` and `lives` update at the edge that leaves PLAY. They are visible in the RELOAD or OVER cycle.
- **Round cadence:** the result is followed by exactly one RELOAD cycle, then PLAY. A round takes at most 17 cycles.
- **Held button:** a button held across RELOAD produces no rise in the new round. It must be released and pressed again.

## Test plan
All directed tests run with `readin_ctrl` connected to a real LED shift stage instance.

1. **Reset:** hold `rst` 2 cycles → all outputs 0 and LEDs 16'hFFFF.
2. **Timeout game:** pulse `start`, keep `btn`=0.
   - Each round: `shift_en` high for 16 cycles, then `miss` pulse, `lives` 3→2→1→0.
   - After the third miss: `game_over`=1, `score`=0, `shift_en` stays low.
3. **Hit:** pulse `start`, press the button matching `target_led` on PLAY cycle 3.
   - Next cycle: `hit`=1, `score`=1, `lives`=3, `shift_en`=0 for one cycle.
   - Then new PLAY with LEDs at 16'hFFFF.
4. **Wrong press:**
   - Press a non-target button → `miss`, `lives`=2.
   - Next round, press `btn`=4'b0011 → `miss`, `lives`=1.
   - Next round, press the correct button on PLAY cycle 15 → `miss` (window has priority), `game_over`=1.
5. **Held button and saturation:**
   - Hold the correct button from RELOAD into PLAY → no hit; timeout miss.
   - Over 260 correct rounds with `LIVES`=15 → `score` saturates at 255.
6. **Reset mid-PLAY:** assert `rst` on PLAY cycle 5 → IDLE next cycle, `shift_en`=0, `score`/`lives`=0, no `hit`/`miss` pulse.

Source files
------------

// File: rtl/readin_ctrl.sv
// Round controller for the LED-drain reaction game: sequences IDLE/PLAY/RELOAD/OVER,
// picks a one-hot target from an LFSR, and scores one press per input window.
module readin_ctrl #(
  parameter int unsigned LIVES   = 3,
  parameter int unsigned SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               readin_en,
  input  logic [3:0]         btn,
  output logic               shift_en,
  output logic [3:0]         target_led,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic               hit,
  output logic               miss,
  output logic               game_over
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_RELOAD = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t               state_q;
  logic [7:0]           lfsr_q;
  logic [1:0]           tgt_q;
  logic [3:0]           btn_prev_q;
  logic [SCORE_W-1:0]   score_q;
  logic [3:0]           lives_q;
  logic                 hit_q;
  logic                 miss_q;

  logic [3:0]           rise;
  logic [3:0]           tgt_oh;
  logic                 lfsr_fb;
  logic                 press;
  logic                 correct;

  always_comb begin
    rise    = btn & ~btn_prev_q;
    tgt_oh  = 4'b0001 << tgt_q;
    press   = |rise;
    correct = (rise == tgt_oh);
    lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= 8'h01;
      tgt_q      <= '0;
      btn_prev_q <= '0;
      score_q    <= '0;
      lives_q    <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      lfsr_q     <= {lfsr_q[6:0], lfsr_fb};
      btn_prev_q <= btn;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            score_q <= '0;
            lives_q <= 4'(LIVES);
            tgt_q   <= lfsr_q[1:0];
            state_q <= S_PLAY;
          end
        end
        S_PLAY: begin
          // A closed window outranks any press seen in the same cycle.
          if (!readin_en || (press && !correct)) begin
            lives_q <= lives_q - 4'd1;
            miss_q  <= 1'b1;
            state_q <= (lives_q == 4'd1) ? S_OVER : S_RELOAD;
          end else if (press) begin
            if (score_q != '1) begin
              score_q <= score_q + {{(SCORE_W-1){1'b0}}, 1'b1};
            end
            hit_q   <= 1'b1;
            state_q <= S_RELOAD;
          end
        end
        S_RELOAD: begin
          tgt_q   <= lfsr_q[1:0];
          state_q <= S_PLAY;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign shift_en   = (state_q == S_PLAY);
  assign target_led = (state_q == S_PLAY) ? tgt_oh : 4'b0000;
  assign game_over  = (state_q == S_OVER);
  assign score      = score_q;
  assign lives      = lives_q;
  assign hit        = hit_q;
  assign miss       = miss_q;

endmodule

// File: tb/tb_readin_ctrl.sv
// Bench for readin_ctrl driving a behavioural 16-bit LED shift stage; round table plus
// scoreboard of expected hit/miss results, reset corner cases and score saturation.
module tb_readin_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       readin_en;
  logic [3:0] btn;
  logic       shift_en;
  logic [3:0] target_led;
  logic [7:0] score;
  logic [3:0] lives;
  logic       hit;
  logic       miss;
  logic       game_over;
  logic [15:0] led;

  logic       s_start;
  logic       s_readin;
  logic [3:0] s_btn;
  logic       s_shift;
  logic [3:0] s_tgt;
  logic [7:0] s_score;
  logic [3:0] s_lives;
  logic       s_hit;
  logic       s_miss;
  logic       s_over;
  logic [15:0] s_led;

  logic [7:0] m_lfsr;
  logic [1:0] m_tgt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         new_game;
    int         press_cyc;
    int         kind;       // 0 none, 1 correct, 2 wrong single, 3 two bits, 4 held from RELOAD
    logic       exp_hit;
    logic [7:0] exp_score;
    logic [3:0] exp_lives;
    logic       exp_over;
  } vec_t;

  typedef struct {
    logic       h;
    logic [7:0] s;
    logic [3:0] l;
    logic       o;
  } exp_t;

  exp_t sb[$];
  exp_t e_chk;

  readin_ctrl #(.LIVES(3), .SCORE_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .readin_en(readin_en), .btn(btn),
    .shift_en(shift_en), .target_led(target_led), .score(score), .lives(lives),
    .hit(hit), .miss(miss), .game_over(game_over)
  );

  readin_ctrl #(.LIVES(15), .SCORE_W(8)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .readin_en(s_readin), .btn(s_btn),
    .shift_en(s_shift), .target_led(s_tgt), .score(s_score), .lives(s_lives),
    .hit(s_hit), .miss(s_miss), .game_over(s_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    led   <= (rst || !shift_en) ? 16'hFFFF : (led >> 1);
    s_led <= (rst || !s_shift)  ? 16'hFFFF : (s_led >> 1);
  end
  assign readin_en = (led[1:0] == 2'b11);
  assign s_readin  = (s_led[1:0] == 2'b11);

  // Reference LFSR: Fibonacci, taps 8,6,5,4; m_tgt is the value sampled at the last edge.
  always @(posedge clk) begin
    if (rst) begin
      m_lfsr <= 8'h01;
      m_tgt  <= 2'd0;
    end else begin
      m_tgt  <= m_lfsr[1:0];
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] pat(input int kind, input logic [1:0] t);
    logic [1:0] w;
    w = t + 2'd1;
    case (kind)
      1, 4:    pat = 4'b0001 << t;
      2:       pat = 4'b0001 << w;
      3:       pat = 4'b0011;
      default: pat = 4'b0000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (hit || miss) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'({hit, miss}), 32'd0);
      end else begin
        e_chk = sb.pop_front();
        chk("res_hit",       32'(hit),        32'(e_chk.h));
        chk("res_miss",      32'(miss),       32'(!e_chk.h));
        chk("res_score",     32'(score),      32'(e_chk.s));
        chk("res_lives",     32'(lives),      32'(e_chk.l));
        chk("res_game_over", 32'(game_over),  32'(e_chk.o));
        chk("res_shift_en",  32'(shift_en),   32'd0);
        chk("res_target",    32'(target_led), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t       tbl[10];
  vec_t       v;
  logic [1:0] t;
  int         n;
  int         exp_len;
  bit         done;
  int         exp_sc;

  initial begin
    tbl[0] = '{1, -1, 0, 1'b0, 8'd0, 4'd2, 1'b0};
    tbl[1] = '{0, -1, 0, 1'b0, 8'd0, 4'd1, 1'b0};
    tbl[2] = '{0, -1, 0, 1'b0, 8'd0, 4'd0, 1'b1};
    tbl[3] = '{1,  3, 1, 1'b1, 8'd1, 4'd3, 1'b0};
    tbl[4] = '{0,  2, 2, 1'b0, 8'd1, 4'd2, 1'b0};
    tbl[5] = '{0,  4, 3, 1'b0, 8'd1, 4'd1, 1'b0};
    tbl[6] = '{0, 15, 1, 1'b0, 8'd1, 4'd0, 1'b1};
    tbl[7] = '{1, -1, 0, 1'b0, 8'd0, 4'd2, 1'b0};
    tbl[8] = '{0, -1, 4, 1'b0, 8'd0, 4'd1, 1'b0};
    tbl[9] = '{0,  0, 1, 1'b1, 8'd1, 4'd1, 1'b0};

    rst = 1'b1; start = 1'b0; btn = 4'b0000; s_start = 1'b0; s_btn = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_shift_en",  32'(shift_en),   32'd0);
    chk("rst_target",    32'(target_led), 32'd0);
    chk("rst_score",     32'(score),      32'd0);
    chk("rst_lives",     32'(lives),      32'd0);
    chk("rst_hit",       32'(hit),        32'd0);
    chk("rst_miss",      32'(miss),       32'd0);
    chk("rst_game_over", 32'(game_over),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_start", 32'(shift_en), 32'd0);

    for (int i = 0; i < 10; i++) begin
      v = tbl[i];
      if (v.new_game) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      t = m_tgt;
      chk("play_entry", 32'(shift_en),   32'd1);
      chk("target",     32'(target_led), 32'(4'b0001 << t));
      sb.push_back('{v.exp_hit, v.exp_score, v.exp_lives, v.exp_over});
      exp_len = ((v.kind >= 1 && v.kind <= 3) && v.press_cyc < 15) ? v.press_cyc + 1 : 16;
      n = 0;
      done = 1'b0;
      while (!done && n < 20) begin
        if (v.kind == 4)           btn = pat(4, t);
        else if (n == v.press_cyc) btn = pat(v.kind, t);
        else                       btn = 4'b0000;
        @(negedge clk);
        n++;
        if (!shift_en) done = 1'b1;
      end
      chk("play_len", 32'(n), 32'(exp_len));
      btn = 4'b0000;
      if (v.exp_over) begin
        repeat (3) @(negedge clk);
        chk("over_flag",  32'(game_over), 32'd1);
        chk("over_shift", 32'(shift_en),  32'd0);
        chk("over_lives", 32'(lives),     32'd0);
        chk("over_score", 32'(score),     32'(v.exp_score));
      end else begin
        // The target for the next round is latched from the LFSR at the RELOAD edge.
        if (i + 1 < 10 && tbl[i+1].kind == 4) btn = pat(4, m_lfsr[1:0]);
        @(negedge clk);
        chk("reload_len", 32'(shift_en), 32'd1);
      end
    end

    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_shift",  32'(shift_en),   32'd0);
    chk("mid_rst_target", 32'(target_led), 32'd0);
    chk("mid_rst_score",  32'(score),      32'd0);
    chk("mid_rst_lives",  32'(lives),      32'd0);
    chk("mid_rst_pulse",  32'({hit, miss}), 32'd0);
    chk("mid_rst_over",   32'(game_over),  32'd0);
    @(negedge clk);
    chk("mid_rst_idle",   32'(shift_en),   32'd0);

    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int r = 0; r < 260; r++) begin
      s_btn = s_tgt;
      @(negedge clk);
      exp_sc = (r + 1 > 255) ? 255 : r + 1;
      chk("sat_hit",   32'(s_hit),   32'd1);
      chk("sat_miss",  32'(s_miss),  32'd0);
      chk("sat_score", 32'(s_score), 32'(exp_sc));
      s_btn = 4'b0000;
      @(negedge clk);
    end
    chk("sat_lives", 32'(s_lives), 32'd15);
    chk("sat_over",  32'(s_over),  32'd0);
    chk("sb_empty",  32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
